trigout_ts_queue: RTL and testbench

TRIGOUT_TS_QUEUE -- requirements
Module: trigout_ts_queue

---
 rtl/trigout_pkg.sv | 26 ++
 rtl/trigout_ts_queue_if.sv | 30 +++
 rtl/trigout_ts_fifo.sv | 85 ++++++++
 rtl/trigout_ts_queue.sv | 131 +++++++++++++
 tb/tb_trigout_ts_queue.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trigout_pkg.sv
// Shared types for the trigger-out timestamp queue: source count, timestamp
// entry layout and the capture FSM state encoding.
package trigout_pkg;

  localparam int C_NSRC  = 5;
  localparam int C_SEC_W = 40;
  localparam int C_CYC_W = 28;

  typedef struct packed {
    logic [C_SEC_W-1:0] sec;
    logic [C_CYC_W-1:0] cycles;
    logic [C_NSRC-1:0]  mask;
  } ts_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUSH    = 2'd2
  } trig_state_t;

  // Window counter load value for a given coalescing window length.
  function automatic logic [3:0] win_load(input int coalesce);
    return 4'(coalesce - 1);
  endfunction

endpackage

// File: rtl/trigout_ts_queue_if.sv
// Readout bus between the timestamp queue and the register bank.
// master = register bank (issues pops), slave = queue (presents head entry).
interface trigout_ts_queue_if;

  logic        ts_rd_i;
  logic [39:0] ts_sec_o;
  logic [27:0] ts_cycles_o;
  logic [4:0]  ts_mask_o;
  logic        ts_present_o;
  logic [7:0]  ovf_cnt_o;

  modport master (
    output ts_rd_i,
    input  ts_sec_o,
    input  ts_cycles_o,
    input  ts_mask_o,
    input  ts_present_o,
    input  ovf_cnt_o
  );

  modport slave (
    input  ts_rd_i,
    output ts_sec_o,
    output ts_cycles_o,
    output ts_mask_o,
    output ts_present_o,
    output ovf_cnt_o
  );

endinterface

// File: rtl/trigout_ts_fifo.sv
// Synchronous FIFO of timestamp entries. The head entry is held in a register
// that is recomputed every cycle from the post-update pointers, so the read
// port is registered, reads zero when empty and shows a freshly written entry
// one cycle after the write into an empty FIFO.
module trigout_ts_fifo
  import trigout_pkg::*;
#(
  parameter int g_DEPTH = 8
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      wr_en_i,
  input  ts_entry_t wr_data_i,
  input  logic      rd_en_i,
  output ts_entry_t rd_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = (g_DEPTH > 1) ? $clog2(g_DEPTH) : 1;
  localparam int CW = $clog2(g_DEPTH + 1);

  ts_entry_t       mem_q [g_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  ts_entry_t       head_q, head_d;
  logic            do_rd, do_wr;

  // Pointer/occupancy update and next head selection (bypass when the write
  // lands exactly on the next read slot).
  always_comb begin
    do_rd    = rd_en_i && (count_q != '0);
    do_wr    = wr_en_i && ((count_q != CW'(g_DEPTH)) || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    head_d = '0;
    if (count_d != '0) begin
      if (do_wr && (rd_ptr_d == wr_ptr_q)) begin
        head_d = wr_data_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Control and head registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = head_q;
  assign full_o    = (count_q == CW'(g_DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/trigout_ts_queue.sv
// Trigger-out timestamp queue: coalesces trigger hits that arrive within a
// short window into one {seconds, cycles, source mask} entry, stamped with the
// WR time of the first hit, and queues the entries for register readout.
// Optional build macro: TRIGOUT_TS_OVERFLOW_EN -- builds the dropped-entry
// counter on ovf_cnt_o; without it ovf_cnt_o is tied to zero (drops still
// happen when the queue is full).
//
// state   | meaning
// IDLE    | waiting for the first enabled hit
// COLLECT | window open, OR-ing further hits into the mask
// PUSH    | entry written to the FIFO this cycle; hits are ignored
module trigout_ts_queue
  import trigout_pkg::*;
#(
  parameter int g_DEPTH    = 8,
  parameter int g_COALESCE = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [C_NSRC-1:0] trig_i,
  input  logic [C_NSRC-1:0] enable_i,
  input  logic              tm_valid_i,
  input  logic [C_SEC_W-1:0] tm_tai_i,
  input  logic [C_CYC_W-1:0] tm_cycles_i,
  trigout_ts_queue_if.slave ts_bus
);

  localparam logic [3:0] C_WIN_LOAD = win_load(g_COALESCE);

  trig_state_t        state_q;
  logic [3:0]         win_cnt_q;
  ts_entry_t          entry_q;
  logic               push_q;
  logic [C_NSRC-1:0]  hit;
  ts_entry_t          fifo_head;
  logic               fifo_full;
  logic               fifo_empty;

  // Enabled hits only count while WR time is valid.
  always_comb begin
    hit = '0;
    if (tm_valid_i) begin
      hit = trig_i & enable_i;
    end
  end

  // Capture FSM: timestamp latched on the opening hit, mask accumulated over
  // the window, one-cycle registered push strobe at the end.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      entry_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit != '0) begin
            state_q        <= COLLECT;
            win_cnt_q      <= C_WIN_LOAD;
            entry_q.sec    <= tm_tai_i;
            entry_q.cycles <= tm_cycles_i;
            entry_q.mask   <= hit;
          end
        end
        COLLECT: begin
          entry_q.mask <= entry_q.mask | hit;
          if (win_cnt_q == '0) begin
            state_q <= PUSH;
            push_q  <= 1'b1;
          end else begin
            win_cnt_q <= win_cnt_q - 4'd1;
          end
        end
        PUSH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  trigout_ts_fifo #(
    .g_DEPTH (g_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (push_q),
    .wr_data_i (entry_q),
    .rd_en_i   (ts_bus.ts_rd_i),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign ts_bus.ts_sec_o     = fifo_head.sec;
  assign ts_bus.ts_cycles_o  = fifo_head.cycles;
  assign ts_bus.ts_mask_o    = fifo_head.mask;
  assign ts_bus.ts_present_o = !fifo_empty;

`ifdef TRIGOUT_TS_OVERFLOW_EN
  logic [7:0] ovf_q, ovf_d;

  // A push is lost only when full and not relieved by a same-cycle pop.
  always_comb begin
    ovf_d = ovf_q;
    if (push_q && fifo_full && !(ts_bus.ts_rd_i && !fifo_empty) && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // Saturating dropped-entry counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ts_bus.ovf_cnt_o = ovf_q;
`else
  logic unused_full;
  assign unused_full      = fifo_full;
  assign ts_bus.ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_trigout_ts_queue.sv
// Bench for trigout_ts_queue: directed scenarios followed by random traffic,
// all checked every cycle against an event-level queue model.
module tb_trigout_ts_queue;
  import trigout_pkg::*;

  localparam int D = 8;
  localparam int C = 4;
`ifdef TRIGOUT_TS_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  trig  = '0;
  logic [4:0]  en    = '0;
  logic        valid = 1'b0;
  logic [39:0] tai   = '0;
  logic [27:0] tcyc  = '0;

  trigout_ts_queue_if ts_if ();

  trigout_ts_queue #(
    .g_DEPTH    (D),
    .g_COALESCE (C)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .trig_i      (trig),
    .enable_i    (en),
    .tm_valid_i  (valid),
    .tm_tai_i    (tai),
    .tm_cycles_i (tcyc),
    .ts_bus      (ts_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of entries plus the open coalescing window,
  // tracked by absolute cycle numbers.
  ts_entry_t q[$];
  bit        m_open  = 1'b0;
  int        m_start = 0;
  ts_entry_t m_cur;
  int        m_ovf   = 0;
  int        ncyc    = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [4:0] h;
    bit do_pop, do_push;
    if (!rst_n) begin
      q.delete();
      m_open = 1'b0;
      m_ovf  = 0;
    end else begin
      h       = valid ? (trig & en) : 5'h00;
      do_pop  = ts_if.ts_rd_i && (q.size() != 0);
      do_push = 1'b0;
      if (m_open) begin
        if (ncyc <= m_start + C) m_cur.mask = m_cur.mask | h;
        else begin
          do_push = 1'b1;
          m_open  = 1'b0;
        end
      end else if (h != 5'h00) begin
        m_open      = 1'b1;
        m_start     = ncyc;
        m_cur.sec   = tai;
        m_cur.cycles = tcyc;
        m_cur.mask  = h;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (q.size() < D) q.push_back(m_cur);
        else if (OVF_EN && m_ovf < 255) m_ovf++;
      end
    end
    ncyc++;
  endtask

  task automatic check_all();
    ts_entry_t e;
    e = (q.size() != 0) ? q[0] : '0;
    chk("present", 80'(ts_if.ts_present_o), 80'(q.size() != 0));
    chk("sec",     80'(ts_if.ts_sec_o),     80'(e.sec));
    chk("cycles",  80'(ts_if.ts_cycles_o),  80'(e.cycles));
    chk("mask",    80'(ts_if.ts_mask_o),    80'(e.mask));
    chk("ovf",     80'(ts_if.ovf_cnt_o),    80'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    tcyc = tcyc + 28'd1;
  endtask

  task automatic step(input logic [4:0] t, input bit r);
    trig          = t;
    ts_if.ts_rd_i = r;
    tick();
    trig          = '0;
    ts_if.ts_rd_i = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(5'h00, 1'b0);
  endtask

  initial begin
    ts_if.ts_rd_i = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_present", 80'(ts_if.ts_present_o), 80'd0);
    chk("rst_sec",     80'(ts_if.ts_sec_o),     80'd0);
    chk("rst_ovf",     80'(ts_if.ovf_cnt_o),    80'd0);

    // Single trigger, latency and contents.
    en = 5'h1F; valid = 1'b1;
    tai = 40'h12_3456_789A; tcyc = 28'd100;
    step(5'h01, 1'b0);
    tai = 40'h0;
    idle(C);
    chk("lat_not_yet", 80'(ts_if.ts_present_o), 80'd0);
    idle(1);
    chk("lat_present", 80'(ts_if.ts_present_o), 80'd1);
    chk("s1_sec",      80'(ts_if.ts_sec_o),     80'h12_3456_789A);
    chk("s1_cycles",   80'(ts_if.ts_cycles_o),  80'd100);
    chk("s1_mask",     80'(ts_if.ts_mask_o),    80'h01);
    step(5'h00, 1'b1);
    chk("s1_popped",   80'(ts_if.ts_present_o), 80'd0);

    // Coalescing of ch1 / ch3 / ext into one entry.
    tcyc = 28'd500;
    step(5'h01, 1'b0);
    idle(1);
    step(5'h04, 1'b0);
    step(5'h10, 1'b0);
    idle(2);
    chk("coal_mask",   80'(ts_if.ts_mask_o),    80'h15);
    chk("coal_cycles", 80'(ts_if.ts_cycles_o),  80'd500);
    step(5'h00, 1'b1);

    // tm_valid dropping inside the window keeps the entry, ignores that hit.
    step(5'h02, 1'b0);
    valid = 1'b0;
    step(5'h08, 1'b0);
    valid = 1'b1;
    idle(C);
    chk("tmv_mask",    80'(ts_if.ts_mask_o),    80'h02);
    step(5'h00, 1'b1);

    // Disabled sources, invalid time and reads while empty.
    en = 5'h00;
    step(5'h1F, 1'b0);
    idle(C + 3);
    en = 5'h1F; valid = 1'b0;
    step(5'h1F, 1'b0);
    idle(C + 3);
    step(5'h00, 1'b1);
    step(5'h00, 1'b1);
    valid = 1'b1;
    chk("ign_present", 80'(ts_if.ts_present_o), 80'd0);
    chk("ign_mask",    80'(ts_if.ts_mask_o),    80'd0);

    // Nine events into an eight-deep queue.
    for (int k = 1; k <= 9; k++) begin
      tai = 40'(1000 + k);
      step(5'(1 << (k % 5)), 1'b0);
      idle(C + 2);
    end
    chk("ovf_nine", 80'(ts_if.ovf_cnt_o), 80'(OVF_EN ? 1 : 0));
    for (int k = 1; k <= 8; k++) begin
      chk("order_sec", 80'(ts_if.ts_sec_o), 80'(1000 + k));
      step(5'h00, 1'b1);
    end
    chk("drain_empty", 80'(ts_if.ts_present_o), 80'd0);

    // Full queue with push and pop in the same cycle.
    for (int k = 1; k <= 8; k++) begin
      tai = 40'(2000 + k);
      step(5'h01, 1'b0);
      idle(C + 2);
    end
    tai = 40'd2009;
    step(5'h02, 1'b0);
    idle(C);
    step(5'h00, 1'b1);
    chk("full_pp_ovf", 80'(ts_if.ovf_cnt_o), 80'(OVF_EN ? 1 : 0));
    for (int k = 2; k <= 9; k++) begin
      chk("full_pp_sec", 80'(ts_if.ts_sec_o), 80'(2000 + k));
      step(5'h00, 1'b1);
    end
    chk("full_pp_empty", 80'(ts_if.ts_present_o), 80'd0);

    // Reset in the middle of a window with entries queued.
    for (int k = 1; k <= 3; k++) begin
      tai = 40'(3000 + k);
      step(5'h01, 1'b0);
      idle(C + 2);
    end
    tai = 40'd3100;
    step(5'h01, 1'b0);
    idle(1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_present", 80'(ts_if.ts_present_o), 80'd0);
    chk("mrst_sec",     80'(ts_if.ts_sec_o),     80'd0);
    chk("mrst_cycles",  80'(ts_if.ts_cycles_o),  80'd0);
    chk("mrst_mask",    80'(ts_if.ts_mask_o),    80'd0);
    chk("mrst_ovf",     80'(ts_if.ovf_cnt_o),    80'd0);
    idle(C + 3);
    chk("mrst_no_ghost", 80'(ts_if.ts_present_o), 80'd0);
    tai = 40'd3200;
    step(5'h04, 1'b0);
    idle(C + 1);
    chk("mrst_new_sec",  80'(ts_if.ts_sec_o),    80'd3200);
    chk("mrst_new_mask", 80'(ts_if.ts_mask_o),   80'h04);
    step(5'h00, 1'b1);
    chk("mrst_sole",     80'(ts_if.ts_present_o), 80'd0);

    // Random traffic; read rate varies per block so the queue also fills.
    for (int blk = 0; blk < 8; blk++) begin
      int rd_div;
      rd_div = (blk % 2 == 0) ? 20 : 3;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 31) == 0) en = 5'($urandom);
        valid = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 7) == 0) tai = {8'($urandom), 32'($urandom)};
        rst_n = ($urandom_range(0, 499) != 0);
        step(($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'h00,
             ($urandom_range(0, rd_div) == 0));
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
